rom_port_arbiter: RTL and testbench

- Shares the single read port of the program ROM between the CPU instruction-fetch unit and the LPM (load program memory) data path.
- Two-way round-robin arbitration.
- Word fetches for the fetch unit; byte extraction for LPM.
- Two-stage pipelined read matching the ROM's falling-edge output register. Sits between the CPU core and the ROM instance.

---
 rtl/rom_port_arbiter_pkg.sv | 34 +++
 rtl/rom_port_arbiter_if.sv | 36 +++
 rtl/rom_port_arbiter_rr_arbiter.sv | 48 ++++
 rtl/rom_port_arbiter.sv | 90 +++++++++
 tb/tb_rom_port_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/rom_port_arbiter_pkg.sv
// Shared encodings and helpers for the program-ROM port arbiter.
package rom_arb_pkg;

    localparam int unsigned LPM_DATA_WIDTH = 8;
    localparam int unsigned ROM_WORD_WIDTH = 16;

    // Which requester owns a read in flight; also the bit index in req/gnt vectors.
    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LPM = 1'b1
    } owner_e;

    // Which half of the ROM word an LPM read returns.
    typedef enum logic {
        BYTE_LO = 1'b0,
        BYTE_HI = 1'b1
    } bytesel_e;

    // Stage-1 control carried alongside the registered ROM address.
    typedef struct packed {
        logic     valid;
        owner_e   owner;
        bytesel_e bytesel;
    } s1_ctrl_t;

    // Pick the addressed byte out of a ROM word.
    function automatic logic [LPM_DATA_WIDTH-1:0] select_byte(
        input logic [ROM_WORD_WIDTH-1:0] word,
        input bytesel_e                  sel
    );
        select_byte = (sel == BYTE_HI) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Bus bundle between the CPU core, the arbiter and the ROM instance.
interface rom_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
);
    import rom_arb_pkg::*;

    logic                      if_req;
    logic [ADDR_WIDTH-1:0]     if_addr;
    logic                      if_flush;
    logic                      if_gnt;
    logic                      if_rvalid;
    logic [DATA_WIDTH-1:0]     if_rdata;

    logic                      lpm_req;
    logic [ADDR_WIDTH:0]       lpm_addr;
    logic                      lpm_gnt;
    logic                      lpm_rvalid;
    logic [LPM_DATA_WIDTH-1:0] lpm_rdata;

    logic [ADDR_WIDTH-1:0]     rom_addr;
    logic [DATA_WIDTH-1:0]     rom_data;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, if_flush, lpm_req, lpm_addr, rom_data,
        output if_gnt, if_rvalid, if_rdata, lpm_gnt, lpm_rvalid, lpm_rdata, rom_addr
    );

    // Core/ROM side.
    modport master (
        output if_req, if_addr, if_flush, lpm_req, lpm_addr, rom_data,
        input  if_gnt, if_rvalid, if_rdata, lpm_gnt, lpm_rvalid, lpm_rdata, rom_addr
    );

endinterface

// File: rtl/rom_port_arbiter_rr_arbiter.sv
// Two-way round-robin arbiter; grant is combinational, history is registered.
module rom_rr_arbiter
    import rom_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    output logic [1:0] gnt_o
);

    owner_e     last_q;
    owner_e     last_d;
    logic [1:0] eff_req;

    assign eff_req = req_i & ~mask_i;

    // One-hot grant: lone requester wins, a tie goes to whoever did not win last.
    always_comb begin
        gnt_o = 2'b00;
        case (eff_req)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_q == OWN_LPM) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    // History moves only when a grant is actually given (grant implies request).
    always_comb begin
        last_d = last_q;
        if (gnt_o[0]) begin
            last_d = OWN_IF;
        end else if (gnt_o[1]) begin
            last_d = OWN_LPM;
        end
    end

    // History register; reset to LPM so fetch wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= OWN_LPM;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the program-ROM read port between instruction fetch and LPM with a 2-cycle pipeline.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    rom_port_arbiter_if.slave   bus
);

    logic [1:0]                req;
    logic [1:0]                mask;
    logic [1:0]                gnt;

    logic [ADDR_WIDTH-1:0]     rom_addr_q, rom_addr_d;
    s1_ctrl_t                  s1_q, s1_d;

    logic                      if_rvalid_q, if_rvalid_d;
    logic [DATA_WIDTH-1:0]     if_rdata_q, if_rdata_d;
    logic                      lpm_rvalid_q, lpm_rvalid_d;
    logic [LPM_DATA_WIDTH-1:0] lpm_rdata_q, lpm_rdata_d;

    assign req  = {bus.lpm_req, bus.if_req};
    assign mask = {1'b0, bus.if_flush};

    rom_rr_arbiter u_arb (
        .clk    (clk),
        .reset  (reset),
        .req_i  (req),
        .mask_i (mask),
        .gnt_o  (gnt)
    );

    assign bus.if_gnt  = gnt[0];
    assign bus.lpm_gnt = gnt[1];

    // Stage 1: capture the word address and owner of the accepted request.
    always_comb begin
        rom_addr_d   = rom_addr_q;
        s1_d         = s1_q;
        s1_d.valid   = 1'b0;
        if (gnt[0]) begin
            rom_addr_d   = bus.if_addr;
            s1_d.valid   = 1'b1;
            s1_d.owner   = OWN_IF;
            s1_d.bytesel = BYTE_LO;
        end else if (gnt[1]) begin
            rom_addr_d   = bus.lpm_addr[ADDR_WIDTH:1];
            s1_d.valid   = 1'b1;
            s1_d.owner   = OWN_LPM;
            s1_d.bytesel = bytesel_e'(bus.lpm_addr[0]);
        end
    end

    // Stage 2: route the falling-edge ROM word to its owner; a flush kills a pending fetch.
    always_comb begin
        if_rvalid_d  = s1_q.valid && (s1_q.owner == OWN_IF) && !bus.if_flush;
        lpm_rvalid_d = s1_q.valid && (s1_q.owner == OWN_LPM);
        if_rdata_d   = if_rvalid_d  ? bus.rom_data : if_rdata_q;
        lpm_rdata_d  = lpm_rvalid_d ? select_byte(bus.rom_data, s1_q.bytesel) : lpm_rdata_q;
    end

    // Pipeline registers; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr_q   <= '0;
            s1_q         <= '{valid: 1'b0, owner: OWN_IF, bytesel: BYTE_LO};
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            lpm_rvalid_q <= 1'b0;
            lpm_rdata_q  <= '0;
        end else begin
            rom_addr_q   <= rom_addr_d;
            s1_q         <= s1_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            lpm_rvalid_q <= lpm_rvalid_d;
            lpm_rdata_q  <= lpm_rdata_d;
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.if_rvalid  = if_rvalid_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.lpm_rvalid = lpm_rvalid_q;
    assign bus.lpm_rdata  = lpm_rdata_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench with a response scoreboard for rom_port_arbiter.
module tb_rom_port_arbiter;
    import rom_arb_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;

    typedef struct {
        logic        lpm;
        logic [15:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q[$];

    logic [DW-1:0] rom [0:(1<<AW)-1];

    rom_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    rom_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: output register updates on the falling edge.
    always @(negedge clk) bus.rom_data <= rom[bus.rom_addr];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Response monitor: every rvalid must match the oldest expectation and its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus.if_rvalid && bus.lpm_rvalid) begin
            n_checks++;
            n_fail++;
            $display("FAIL dual_rvalid cyc=%0d actual=both required=one", cyc);
        end
        if (bus.if_rvalid || bus.lpm_rvalid) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rvalid cyc=%0d actual=lpm%0b/%h/%h required=none",
                         cyc, bus.lpm_rvalid, bus.if_rdata, bus.lpm_rdata);
            end else begin
                logic [15:0] data;
                e = q.pop_front();
                data = bus.lpm_rvalid ? {8'h00, bus.lpm_rdata} : bus.if_rdata;
                if (bus.lpm_rvalid !== e.lpm || data !== e.data || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL response cyc=%0d actual=lpm%0b/%h required=lpm%0b/%h@%0d",
                             cyc, bus.lpm_rvalid, data, e.lpm, e.data, e.due);
                end
            end
        end else if (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_rvalid cyc=%0d actual=none required=lpm%0b/%h@%0d",
                     cyc, e.lpm, e.data, e.due);
        end
    end

    // One cycle of stimulus; checks grants (and rom_addr when erom >= 0) mid-cycle.
    task automatic step(input logic ireq, input logic [AW-1:0] iaddr, input logic ifl,
                        input logic lreq, input logic [AW:0] laddr,
                        input logic eig, input logic elg,
                        input logic push, input logic elpm, input logic [15:0] edat,
                        input int erom);
        @(posedge clk);
        #1;
        bus.if_req   = ireq;
        bus.if_addr  = iaddr;
        bus.if_flush = ifl;
        bus.lpm_req  = lreq;
        bus.lpm_addr = laddr;
        @(negedge clk);
        chk("if_gnt", 16'(bus.if_gnt), 16'(eig));
        chk("lpm_gnt", 16'(bus.lpm_gnt), 16'(elg));
        if (erom >= 0) chk("rom_addr", 16'(bus.rom_addr), 16'(erom));
        if (push) q.push_back('{lpm: elpm, data: edat, due: cyc + 2});
    endtask

    task automatic idle(input int erom);
        step(1'b0, 8'd0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, erom);
    endtask

    // One reset cycle, then check the reset state.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.if_req = 1'b0; bus.if_flush = 1'b0; bus.lpm_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rom_addr", 16'(bus.rom_addr), 16'h0);
        chk("rst_if_rvalid", 16'(bus.if_rvalid), 16'h0);
        chk("rst_lpm_rvalid", 16'(bus.lpm_rvalid), 16'h0);
        chk("rst_if_rdata", bus.if_rdata, 16'h0);
        chk("rst_lpm_rdata", 16'(bus.lpm_rdata), 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom[i] = 16'(i * 257) ^ 16'h5A5A;
        rom[0] = 16'hE80B; rom[1] = 16'hBB09; rom[2] = 16'hE011;
        rom[3] = 16'hBB18; rom[4] = 16'hE027; rom[5] = 16'h9426;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.lpm_req = 1'b0; bus.lpm_addr = '0; bus.rom_data = '0;

        do_reset();

        // Single fetch from address 0.
        step(1, 8'd0, 0, 0, 9'd0, 1, 0, 1, 0, 16'hE80B, 0);
        idle(0);
        idle(0);

        // Back-to-back fetches.
        step(1, 8'd0, 0, 0, 9'd0, 1, 0, 1, 0, 16'hE80B, 0);
        step(1, 8'd1, 0, 0, 9'd0, 1, 0, 1, 0, 16'hBB09, 0);
        step(1, 8'd2, 0, 0, 9'd0, 1, 0, 1, 0, 16'hE011, 1);
        step(1, 8'd3, 0, 0, 9'd0, 1, 0, 1, 0, 16'hBB18, 2);
        idle(3);
        idle(3);
        idle(3);

        // LPM-only byte reads.
        step(0, 8'd0, 0, 1, 9'd3,  0, 1, 1, 1, 16'h00BB, 3);
        step(0, 8'd0, 0, 1, 9'd10, 0, 1, 1, 1, 16'h0026, 1);
        step(0, 8'd0, 0, 1, 9'd4,  0, 1, 1, 1, 16'h0011, 5);
        idle(2);
        idle(2);
        idle(2);

        // Continuous tie after reset: IF first, then alternate.
        do_reset();
        step(1, 8'd4, 0, 1, 9'd2, 1, 0, 1, 0, 16'hE027, 0);
        step(1, 8'd4, 0, 1, 9'd2, 0, 1, 1, 1, 16'h0009, 4);
        step(1, 8'd4, 0, 1, 9'd2, 1, 0, 1, 0, 16'hE027, 1);
        step(1, 8'd4, 0, 1, 9'd2, 0, 1, 1, 1, 16'h0009, 4);
        idle(1);
        idle(1);
        idle(1);

        // Flush kills the fetch in stage 1; LPM granted in the flush cycle still returns.
        step(1, 8'd0, 0, 0, 9'd0, 1, 0, 0, 0, 16'h0, 1);
        step(1, 8'd1, 1, 1, 9'd3, 0, 1, 1, 1, 16'h00BB, 0);
        idle(1);
        idle(1);
        idle(1);

        // A fetch already delivering in the flush cycle is kept; flush masks a lone fetch.
        step(1, 8'd1, 0, 0, 9'd0, 1, 0, 1, 0, 16'hBB09, 1);
        idle(1);
        step(1, 8'd2, 1, 0, 9'd0, 0, 0, 0, 0, 16'h0, 1);
        idle(1);

        // LPM in stage 1 is unaffected by a flush.
        step(0, 8'd0, 0, 1, 9'd4, 0, 1, 1, 1, 16'h0011, 1);
        step(1, 8'd3, 1, 0, 9'd0, 0, 0, 0, 0, 16'h0, 2);
        idle(2);
        idle(2);

        // Reset right after an LPM acceptance drops the read.
        step(0, 8'd0, 0, 1, 9'd10, 0, 1, 0, 1, 16'h0, 2);
        do_reset();
        step(1, 8'd4, 0, 1, 9'd2, 1, 0, 1, 0, 16'hE027, 0);
        idle(4);
        idle(4);
        idle(4);

        chk("queue_drained", 16'(q.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
